mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port MemWrapper (16-bit addr/data, sync write, 1-cycle read latency) between
//  instruction fetch (IF) and data memory (DM) requesters. Issues at most one access per cycle,
//  returns read data one cycle later to the issuing port, prevents fetch starvation.
//  Sits between the datapath fetch/mem stages and the MemWrapper instance.
// PARAMETERS
//  ADDR_W      16  address width (matches MemWrapper addr_in)
//  DATA_W      16  data width (matches MemWrapper dataw_in/mem_out)
//  STARVE_MAX  3   consecutive IF-denied cycles after which IF wins the next arbitration (>=1)
// PORTS
//  CLK        in   1       system clock, rising edge
//  RST_N      in   1       asynchronous active-low reset
//  if_req     in   1       IF read request; held with if_addr until if_gnt
//  if_addr    in   ADDR_W  IF read address
//  if_gnt     out  1       IF request accepted this cycle
//  if_rvalid  out  1       if_rdata valid (cycle after if_gnt)
//  if_rdata   out  DATA_W  IF read data
//  dm_req     in   1       DM request; held with dm_we/dm_addr/dm_wdata until dm_gnt
//  dm_we      in   1       1 = write, 0 = read
//  dm_addr    in   ADDR_W  DM address
//  dm_wdata   in   DATA_W  DM write data
//  dm_gnt     out  1       DM request accepted this cycle
//  dm_rvalid  out  1       dm_rdata valid (cycle after a DM read grant; never for writes)
//  dm_rdata   out  DATA_W  DM read data
//  mem_addr   out  ADDR_W  to MemWrapper addr_in
//  mem_din    out  DATA_W  to MemWrapper dataw_in
//  mem_we     out  1       to MemWrapper memw
//  mem_dout   in   DATA_W  from MemWrapper mem_out
// BEHAVIOUR
//  - Reset: if_gnt/dm_gnt/if_rvalid/dm_rvalid/mem_we = 0; if_rdata/dm_rdata = 0; starve_cnt = 0;
//    owner = NONE. Async assert, sync release; mem_we forced 0 while RST_N low.
//  - Grant (combinational from req + starve_cnt, same cycle): only one of if_gnt/dm_gnt high.
//    Both req: DM wins unless starve_cnt == STARVE_MAX, then IF wins. Single req: that port wins.
//  - mem_addr/mem_din/mem_we driven combinationally from granted port; mem_we = dm_gnt & dm_we.
//    No grant: mem_addr holds last issued addr, mem_we = 0.
//  - starve_cnt: +1 when if_req & !if_gnt (saturate STARVE_MAX); clear on if_gnt or !if_req.
//  - Owner register (NONE/IF/DM_RD) latched at each edge from the grant: a DM write sets NONE.
//  - Cycle T+1 after read grant: owner's rvalid = 1, rdata = mem_dout, registered. Other port's
//    rvalid = 0, its rdata holds its last value.
//  - Fully pipelined: new grant allowed every cycle incl. the cycle a previous read returns;
//    sustained throughput 1 access/cycle.
//  - DM write then DM/IF read of same addr next cycle returns the new data (memory write-first
//    at the edge).
//  - Reset mid-read: outstanding read dropped, no rvalid after release.
//  - Request deasserted before grant is legal and discarded; no state beyond starve_cnt clear.
// CONFIGURATION
//  ARB_STATS_EN defined: outputs if_grant_cnt, dm_grant_cnt (16-bit each), saturating at 16'hFFFF,
//   +1 per if_gnt/dm_gnt, cleared by reset. Not defined: ports and counters absent, no other change.
// TESTING  (MemWrapper preload: 0000=1234, 0001=1337, 0002=dead)
//  1 if_req, if_addr=0000, dm_req=0 -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=1234.
//  2 dm_req rd 0001 + if_req 0002 same cycle -> dm_gnt first, dm_rdata=1337; IF granted next
//    cycle, if_rdata=dead.
//  3 DM write 0001=1111, then DM read 0001 next cycle -> mem_we=1 for one cycle only; no dm_rvalid
//    for write; dm_rdata=1111.
//  4 dm_req held continuously, if_req held, STARVE_MAX=3 -> IF granted on 4th contended cycle;
//    pattern DM,DM,DM,IF repeats.
//  5 Read granted, RST_N low before next edge -> no rvalid, all outputs at reset values; first
//    grant after release behaves as test 1.
//  6 ARB_STATS_EN: 5 IF + 2 DM grants -> if_grant_cnt=5, dm_grant_cnt=2; 0 after reset.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/grant/read-return bundle between the fetch and data-memory requesters,
// the arbiter, and the single-port memory wrapper.
// Modports: slave = arbiter side, master = requesters plus memory side (datapath, bench).
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   // instruction fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   // data memory port
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;
   // memory wrapper side
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic              mem_we;
   logic [DATA_W-1:0] mem_dout;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_dout,
      output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_addr, mem_din, mem_we
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_dout,
      input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_addr, mem_din, mem_we
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port memory between instruction fetch (IF) and data memory (DM).
// Latency: grant is combinational in the request cycle; read data returns the following cycle.
// Backpressure: a denied requester holds its request; IF wins after STARVE_MAX denied cycles.
// Ports: clk, rst_n (async active-low); bus (mem_port_arbiter_if.slave) carries both
// requester ports and the memory wrapper connection.
// Optional: define ARB_STATS_EN to add saturating grant counters if_grant_cnt / dm_grant_cnt.
module mem_port_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int STARVE_MAX = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef ARB_STATS_EN
   output logic [15:0]           if_grant_cnt,
   output logic [15:0]           dm_grant_cnt,
`endif
   mem_port_arbiter_if.slave     bus
);

   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_IF    = 2'd1,
      OWN_DM_RD = 2'd2
   } owner_t;

   owner_t            owner;
   logic [CNT_W-1:0]  starve_cnt;
   logic [ADDR_W-1:0] last_addr;
   logic [DATA_W-1:0] if_hold;
   logic [DATA_W-1:0] dm_hold;
   logic              if_win;
   logic              dm_win;

   // Grants are gated by rst_n so nothing (in particular a write) reaches the
   // memory while reset is asserted.
   always_comb begin
      if_win = 1'b0;
      dm_win = 1'b0;
      if (rst_n) begin
         if (bus.if_req && bus.dm_req) begin
            if (starve_cnt == STARVE_LIM) if_win = 1'b1;
            else                          dm_win = 1'b1;
         end else if (bus.if_req) begin
            if_win = 1'b1;
         end else if (bus.dm_req) begin
            dm_win = 1'b1;
         end
      end
   end

   assign bus.if_gnt   = if_win;
   assign bus.dm_gnt   = dm_win;
   assign bus.mem_addr = if_win ? bus.if_addr : (dm_win ? bus.dm_addr : last_addr);
   assign bus.mem_din  = bus.dm_wdata;
   assign bus.mem_we   = dm_win & bus.dm_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner      <= OWN_NONE;
         starve_cnt <= '0;
         last_addr  <= '0;
         if_hold    <= '0;
         dm_hold    <= '0;
      end else begin
         // Remember who issued the read so the returning word goes to that port.
         if (if_win)                     owner <= OWN_IF;
         else if (dm_win && !bus.dm_we)  owner <= OWN_DM_RD;
         else                            owner <= OWN_NONE;

         if (bus.if_req && !if_win) begin
            if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
         end else begin
            starve_cnt <= '0;
         end

         if (if_win || dm_win) last_addr <= bus.mem_addr;

         // Capture the returning word so each port keeps showing its last read.
         if (owner == OWN_IF)    if_hold <= bus.mem_dout;
         if (owner == OWN_DM_RD) dm_hold <= bus.mem_dout;
      end
   end

   // The memory output is already a registered read port, so in the return cycle
   // it is forwarded directly; afterwards the captured copy is shown.
   assign bus.if_rvalid = (owner == OWN_IF);
   assign bus.dm_rvalid = (owner == OWN_DM_RD);
   assign bus.if_rdata  = bus.if_rvalid ? bus.mem_dout : if_hold;
   assign bus.dm_rdata  = bus.dm_rvalid ? bus.mem_dout : dm_hold;

`ifdef ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_grant_cnt <= '0;
         dm_grant_cnt <= '0;
      end else begin
         if (if_win && (if_grant_cnt != 16'hFFFF)) if_grant_cnt <= if_grant_cnt + 16'd1;
         if (dm_win && (dm_grant_cnt != 16'hFFFF)) dm_grant_cnt <= dm_grant_cnt + 16'd1;
      end
   end
`endif

endmodule
